pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the ID/EX pipeline register and the stages around it: load-use stalls, branch flushes,
//  and the interlock for the multi-cycle multiply/divide unit. Sits beside the decoder.
//  Drives the PC enable, IF/ID write/flush and the ID/EX bubble (zeroes all ID/EX control fields).
//  Counts stall cycles for performance monitoring.
// PARAMETERS
//  MD_LATENCY  4   cycles the mult/div unit is busy after md_start_EX (legal range 2..15)
//  CNT_W       16  width of stall_count
// PORTS
//  clk             in   1      pipeline clock
//  rst             in   1      reset, asynchronous, active-low
//  rs_ID           in   5      rs field of the instruction in ID
//  rt_ID           in   5      rt field of the instruction in ID
//  use_rs_ID       in   1      ID instruction reads rs
//  use_rt_ID       in   1      ID instruction reads rt
//  md_op_ID        in   1      ID instruction is mult/div/mfhi/mflo
//  MemRead_EX      in   1      EX instruction is a load
//  RegWrite_EX     in   1      EX instruction writes the register file
//  dest_EX         in   5      destination register of the EX instruction
//  branch_taken_EX in   1      branch/jump resolved taken in EX
//  md_start_EX     in   1      EX instruction launches mult/div
//  pc_write        out  1      PC load enable
//  if_id_write     out  1      IF/ID load enable
//  if_id_flush     out  1      IF/ID loads a NOP
//  id_ex_bubble    out  1      ID/EX loads all-zero control
//  md_busy         out  1      mult/div in flight
//  md_done         out  1      one-cycle pulse on the final busy cycle
//  stall_count     out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
//  - rst low: md FSM IDLE, md_cnt=0, stall_count=0. Outputs forced to pc_write=0, if_id_write=0,
//    if_id_flush=1, id_ex_bubble=1, md_busy=0, md_done=0. Release takes effect on the next clk edge.
//  - load_hz = MemRead_EX & RegWrite_EX & dest_EX!=0 & ((use_rs_ID & rs_ID==dest_EX) | (use_rt_ID & rt_ID==dest_EX)).
//  - md_hz   = md_op_ID & (md_busy & ~md_done | md_start_EX).
//  - stall   = (load_hz | md_hz) & ~branch_taken_EX.
//  - Outputs are combinational, decided within the same cycle, with zero-cycle latency:
//    pc_write = if_id_write = ~stall; id_ex_bubble = stall | branch_taken_EX; if_id_flush = branch_taken_EX.
//  - Branch has priority: branch_taken_EX squashes the ID instruction, so a pending stall is dropped
//    and the PC loads the target (pc_write=1).
//  - load_hz lasts exactly 1 cycle: the bubble clears MemRead_EX on the next cycle.
//  - md FSM (IDLE, BUSY):
//    - IDLE & md_start_EX -> BUSY, md_cnt<=MD_LATENCY-1.
//    - BUSY: md_cnt decrements each cycle. When md_cnt==1, md_done=1 and the FSM returns to IDLE next edge,
//      unless md_start_EX is high, in which case it reloads and stays BUSY.
//    - md_busy=1 in BUSY. md_op_ID may proceed in the md_done cycle.
//  - md_start_EX and branch_taken_EX never coincide (one EX instruction). If both are asserted anyway,
//    md_start_EX is honoured and the flush still occurs.
//  - branch_taken_EX while BUSY does not abort the in-flight op, because it is older than the branch.
//  - stall_count += 1 each cycle stall=1 and saturates at all-ones without wrapping.
//    Flush-only cycles are not counted.
//  - Reset mid-operation (BUSY): immediately IDLE, md_busy=0, no md_done pulse.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg: md FSM state encoding (IDLE=0, BUSY=1), REG_IDX_W=5, ZERO_REG=5'd0.
//  - One sub-module: md_latency_counter (loadable down-counter, emits busy and done).
//  - Hazard compare and output logic stay in the top level.
// TESTING
//  - lw $5 in EX, ID add uses rs=$5 -> 1 cycle pc_write=0, id_ex_bubble=1; next cycle pc_write=1.
//  - lw $0 in EX, ID uses rs=$0 -> no stall, stall_count unchanged.
//  - md_start_EX at cycle 0, MD_LATENCY=4, mflo in ID from cycle 1 -> stall cycles 1-2,
//    md_done at cycle 3, mflo advances in cycle 3.
//  - load_hz and branch_taken_EX in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1,
//    stall_count unchanged.
//  - rst low in the 2nd BUSY cycle -> md_busy=0 asynchronously, no md_done;
//    after release, IDLE with stall_count=0.
//  - CNT_W=4, 20 consecutive md stalls -> stall_count holds 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG  = 5'd0;

  // True when an ID source operand is actually read and names the given register.
  function automatic logic reg_match(input logic                 used,
                                     input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
    return used & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder-side bundle: ID/EX hazard inputs and the pipeline control outputs.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] rs_ID;
  logic [REG_IDX_W-1:0] rt_ID;
  logic                 use_rs_ID;
  logic                 use_rt_ID;
  logic                 md_op_ID;
  logic                 MemRead_EX;
  logic                 RegWrite_EX;
  logic [REG_IDX_W-1:0] dest_EX;
  logic                 branch_taken_EX;
  logic                 md_start_EX;
  logic                 pc_write;
  logic                 if_id_write;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 md_busy;
  logic                 md_done;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output rs_ID, rt_ID, use_rs_ID, use_rt_ID, md_op_ID,
    output MemRead_EX, RegWrite_EX, dest_EX, branch_taken_EX, md_start_EX,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
    input  md_busy, md_done, stall_count
  );

  modport slave (
    input  rs_ID, rt_ID, use_rs_ID, use_rt_ID, md_op_ID,
    input  MemRead_EX, RegWrite_EX, dest_EX, branch_taken_EX, md_start_EX,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble,
    output md_busy, md_done, stall_count
  );

endinterface

// File: rtl/md_latency_counter.sv
// Tracks the in-flight mult/div op: loadable down-counter with busy and final-cycle done.
module md_latency_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);

  md_state_e  state_r;
  logic [3:0] cnt_r;

  // md FSM: a start arriving on the done cycle chains straight into the next op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MD_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            state_r <= MD_BUSY;
            cnt_r   <= LOAD_VAL;
          end
        end
        MD_BUSY: begin
          if (start) begin
            cnt_r <= LOAD_VAL;
          end else if (cnt_r == 4'd1) begin
            state_r <= MD_IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign busy = (state_r == MD_BUSY);
  assign done = (state_r == MD_BUSY) && (cnt_r == 4'd1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID/EX hazard controller: load-use and mult/div interlocks, branch flush, stall counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);

  logic             md_busy_s;
  logic             md_done_s;
  logic             load_hz_s;
  logic             md_hz_s;
  logic             stall_s;
  logic [CNT_W-1:0] stall_cnt_r;

  md_latency_counter #(
    .LATENCY (MD_LATENCY)
  ) u_md_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (bus.md_start_EX),
    .busy  (md_busy_s),
    .done  (md_done_s)
  );

  // Hazard detection; a taken branch squashes the ID instruction so it never stalls.
  always_comb begin
    load_hz_s = bus.MemRead_EX & bus.RegWrite_EX & (bus.dest_EX != ZERO_REG) &
                (reg_match(bus.use_rs_ID, bus.rs_ID, bus.dest_EX) |
                 reg_match(bus.use_rt_ID, bus.rt_ID, bus.dest_EX));
    md_hz_s   = bus.md_op_ID & ((md_busy_s & ~md_done_s) | bus.md_start_EX);
    stall_s   = (load_hz_s | md_hz_s) & ~bus.branch_taken_EX;
  end

  // Pipeline controls; held in the safe freeze/flush pattern while reset is low.
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.if_id_write  = 1'b0;
    bus.if_id_flush  = 1'b1;
    bus.id_ex_bubble = 1'b1;
    if (!rst) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else begin
      bus.pc_write     = ~stall_s;
      bus.if_id_write  = ~stall_s;
      bus.if_id_flush  = bus.branch_taken_EX;
      bus.id_ex_bubble = stall_s | bus.branch_taken_EX;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign bus.md_busy     = md_busy_s;
  assign bus.md_done     = md_done_s;
  assign bus.stall_count = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mdop;
    logic       mr;
    logic       rw;
    logic [4:0] dest;
    logic       br;
    logic       st;
  } stim_t;

  typedef struct {
    logic          pcw;
    logic          ifw;
    logic          flush;
    logic          bub;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;
    string         tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    md_left = 0;
  int    stalls = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .MD_LATENCY (LAT),
    .CNT_W      (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.urs = 1'b0; s.urt = 1'b0;
    s.mdop = 1'b0; s.mr = 1'b0; s.rw = 1'b0; s.dest = 5'd0; s.br = 1'b0; s.st = 1'b0;
    return s;
  endfunction

  // Apply one cycle of stimulus and queue what the controller must show in that cycle.
  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    bit   busy_m, done_m, load_m, mdh_m, stall_m;
    @(posedge clk);
    #1;
    rst                 = s.rst;
    bus.rs_ID           = s.rs;
    bus.rt_ID           = s.rt;
    bus.use_rs_ID       = s.urs;
    bus.use_rt_ID       = s.urt;
    bus.md_op_ID        = s.mdop;
    bus.MemRead_EX      = s.mr;
    bus.RegWrite_EX     = s.rw;
    bus.dest_EX         = s.dest;
    bus.branch_taken_EX = s.br;
    bus.md_start_EX     = s.st;

    busy_m  = (md_left > 0);
    done_m  = (md_left == 1);
    load_m  = s.mr && s.rw && (s.dest != 5'd0) &&
              ((s.urs && s.rs == s.dest) || (s.urt && s.rt == s.dest));
    mdh_m   = s.mdop && ((busy_m && !done_m) || s.st);
    stall_m = (load_m || mdh_m) && !s.br;
    e.tag   = tag;
    if (!s.rst) begin
      e.pcw = 1'b0; e.ifw = 1'b0; e.flush = 1'b1; e.bub = 1'b1;
      e.busy = 1'b0; e.done = 1'b0; e.cnt = '0;
      md_left = 0;
      stalls  = 0;
    end else begin
      e.pcw   = !stall_m;
      e.ifw   = !stall_m;
      e.flush = s.br;
      e.bub   = stall_m || s.br;
      e.busy  = busy_m;
      e.done  = done_m;
      e.cnt   = CW'(stalls);
      if (s.st) md_left = LAT - 1;
      else if (busy_m) md_left = md_left - 1;
      if (stall_m && stalls < CNT_MAX) stalls = stalls + 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d at %0t", tag, nm, act, req, $time);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one response mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.tag, "pc_write",     32'(bus.pc_write),     32'(e.pcw));
      chk(e.tag, "if_id_write",  32'(bus.if_id_write),  32'(e.ifw));
      chk(e.tag, "if_id_flush",  32'(bus.if_id_flush),  32'(e.flush));
      chk(e.tag, "id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e.bub));
      chk(e.tag, "md_busy",      32'(bus.md_busy),      32'(e.busy));
      chk(e.tag, "md_done",      32'(bus.md_done),      32'(e.done));
      chk(e.tag, "stall_count",  32'(bus.stall_count),  32'(e.cnt));
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    drive(s, "reset");
    drive(s, "reset");
    s = idle();
    drive(s, "idle");

    s = idle(); s.mr = 1'b1; s.rw = 1'b1; s.dest = 5'd5; s.urs = 1'b1; s.rs = 5'd5;
    drive(s, "load_use");
    s = idle(); s.urs = 1'b1; s.rs = 5'd5; s.dest = 5'd5;
    drive(s, "load_use_next");
    s = idle(); s.mr = 1'b1; s.rw = 1'b1; s.dest = 5'd0; s.urs = 1'b1; s.rs = 5'd0;
    drive(s, "load_r0");
    s = idle();
    drive(s, "after_r0");
    s = idle(); s.mr = 1'b1; s.rw = 1'b1; s.dest = 5'd7; s.urt = 1'b1; s.rt = 5'd7;
    drive(s, "load_rt");

    s = idle(); s.st = 1'b1;
    drive(s, "md_start");
    for (int i = 1; i <= 3; i++) begin
      s = idle(); s.mdop = 1'b1;
      drive(s, $sformatf("mflo_c%0d", i));
    end
    s = idle();
    drive(s, "md_after");

    s = idle(); s.mr = 1'b1; s.rw = 1'b1; s.dest = 5'd3; s.urs = 1'b1; s.rs = 5'd3; s.br = 1'b1;
    drive(s, "load_branch");
    s = idle();
    drive(s, "post_branch");

    s = idle(); s.st = 1'b1;
    drive(s, "md_start2");
    s = idle();
    drive(s, "busy1");
    s = idle(); s.rst = 1'b0;
    drive(s, "rst_busy");
    drive(s, "rst_hold");
    s = idle();
    drive(s, "release");
    drive(s, "release2");

    for (int i = 0; i < 21; i++) begin
      s = idle(); s.mdop = 1'b1; s.st = (i % 3 == 0);
      drive(s, "sat");
    end
    s = idle();
    drive(s, "sat_hold");
    drive(s, "sat_hold2");

    for (int i = 0; i < 400; i++) begin
      s = idle();
      s.rst  = ($urandom_range(0, 49) != 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.dest = 5'($urandom_range(0, 3));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.mr   = 1'($urandom_range(0, 1));
      s.rw   = 1'($urandom_range(0, 1));
      s.mdop = 1'($urandom_range(0, 1));
      s.br   = ($urandom_range(0, 5) == 0);
      s.st   = (md_left <= 1) && ($urandom_range(0, 3) == 0);
      drive(s, "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
